conv3x3_engine: RTL and testbench

- Parametrised 3x3 convolution engine; successor to the fixed Gaussian blur stage.
- Accepts a 9-pixel window from the line-buffer stage and produces one filtered pixel per accepted window.
- Adds runtime-loadable signed coefficients, a programmable normalising shift, absolute/clamp output modes, saturation and full valid/ready backpressure.
- Serves both the Gaussian (blur) and Sobel (gradient) stages of the Canny pipeline.

---
 rtl/conv_pkg.sv | 16 +
 rtl/conv_sat_shift.sv | 47 ++++
 rtl/conv3x3_engine.sv | 118 +++++++++++
 tb/tb_conv3x3_engine.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution engine: tap count, default
// Gaussian kernel, Sobel kernels and the accumulator width derivation.
package conv_pkg;

    localparam int NUM_TAPS = 9;

    localparam int GAUSS_COEF [NUM_TAPS] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    localparam int SOBEL_GX   [NUM_TAPS] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    localparam int SOBEL_GY   [NUM_TAPS] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

    // Nine products of (COEF_W signed) x (DATA_W+1 signed) need 4 extra bits; one spare.
    function automatic int conv_sum_width(input int data_w, input int coef_w);
        return data_w + coef_w + 5;
    endfunction

endpackage

// File: rtl/conv_sat_shift.sv
// Output stage of the convolution engine: sign mode, optional rounding, shift and
// saturation. Rounding is enabled by defining CONV3X3_ROUND_EN.
module conv_sat_shift #(
    parameter int DATA_W  = 8,
    parameter int SUM_W   = 21,
    parameter int SHIFT_W = 4
) (
    input  logic signed [SUM_W-1:0]   sum_in,
    input  logic        [SHIFT_W-1:0] shift,
    input  logic                      abs_en,
    output logic        [DATA_W-1:0]  data_out
);

    localparam int RW = SUM_W + 1;

    logic [RW-1:0] mag;
    logic [RW-1:0] rnd;
    logic [RW-1:0] res;

    always_comb begin
        mag = '0;
        if (sum_in[SUM_W-1]) begin
            if (abs_en) begin
                mag = {1'b0, -sum_in};
            end
        end else begin
            mag = {1'b0, sum_in};
        end

        rnd = mag;
`ifdef CONV3X3_ROUND_EN
        // Half-LSB bias on the magnitude; the spare top bit absorbs any carry.
        if (shift != '0) begin
            rnd = mag + (RW'(1) << (shift - SHIFT_W'(1)));
        end
`endif

        res = rnd >> shift;

        if (res[RW-1:DATA_W] != '0) begin
            data_out = '1;
        end else begin
            data_out = res[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/conv3x3_engine.sv
// Three-stage 3x3 convolution engine with loadable signed coefficients and
// valid/ready backpressure. Define CONV3X3_ROUND_EN for round-half-up output.
module conv3x3_engine
    import conv_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int COEF_W  = 8,
    parameter int SHIFT_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [9*DATA_W-1:0]        in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       coef_wr_en,
    input  logic [3:0]                 coef_wr_addr,
    input  logic signed [COEF_W-1:0]   coef_wr_data,
    input  logic [SHIFT_W-1:0]         cfg_shift,
    input  logic                       cfg_abs
);

    localparam int SUM_W  = conv_sum_width(DATA_W, COEF_W);
    localparam int PROD_W = DATA_W + COEF_W + 1;

    logic signed [COEF_W-1:0] coef_q [NUM_TAPS];
    logic signed [COEF_W-1:0] coef_d [NUM_TAPS];
    logic signed [PROD_W-1:0] prod_q [NUM_TAPS];
    logic signed [PROD_W-1:0] prod_d [NUM_TAPS];
    logic                     s1_valid_q, s1_valid_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic                     s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;

    logic                     advance;
    logic signed [SUM_W-1:0]  sum_acc;
    logic [DATA_W-1:0]        sat_data;

    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    conv_sat_shift #(
        .DATA_W  (DATA_W),
        .SUM_W   (SUM_W),
        .SHIFT_W (SHIFT_W)
    ) u_sat_shift (
        .sum_in   (sum_q),
        .shift    (cfg_shift),
        .abs_en   (cfg_abs),
        .data_out (sat_data)
    );

    always_comb begin
        sum_acc = '0;
        for (int unsigned i = 0; i < NUM_TAPS; i++) begin
            sum_acc = sum_acc + SUM_W'(prod_q[i]);
        end
    end

    always_comb begin
        // Coefficient writes ignore the handshake; S1 below still sees the old value this cycle.
        coef_d = coef_q;
        for (int unsigned i = 0; i < NUM_TAPS; i++) begin
            if (coef_wr_en && coef_wr_addr == 4'(i)) begin
                coef_d[i] = coef_wr_data;
            end
        end

        prod_d      = prod_q;
        s1_valid_d  = s1_valid_q;
        sum_d       = sum_q;
        s2_valid_d  = s2_valid_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (advance) begin
            s1_valid_d = in_valid;
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                prod_d[i] = PROD_W'(coef_q[i]) *
                            PROD_W'($signed({1'b0, in_data[i*DATA_W +: DATA_W]}));
            end
            s2_valid_d  = s1_valid_q;
            sum_d       = sum_acc;
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_data_d = sat_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                coef_q[i] <= COEF_W'(GAUSS_COEF[i]);
                prod_q[i] <= '0;
            end
            s1_valid_q  <= 1'b0;
            sum_q       <= '0;
            s2_valid_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            coef_q      <= coef_d;
            prod_q      <= prod_d;
            s1_valid_q  <= s1_valid_d;
            sum_q       <= sum_d;
            s2_valid_q  <= s2_valid_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed self-checking bench for conv3x3_engine; expected pixels are hand-computed.
module tb_conv3x3_engine;
    import conv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [71:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        coef_wr_en;
    logic [3:0]  coef_wr_addr;
    logic [7:0]  coef_wr_data;
    logic [3:0]  cfg_shift;
    logic        cfg_abs;

    int checks;
    int failures;

    conv3x3_engine #(
        .DATA_W  (8),
        .COEF_W  (8),
        .SHIFT_W (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data),
        .cfg_shift    (cfg_shift),
        .cfg_abs      (cfg_abs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [71:0] uni(input logic [7:0] v);
        return {9{v}};
    endfunction

    function automatic logic [71:0] cols(input logic [7:0] l, input logic [7:0] m, input logic [7:0] r);
        logic [71:0] w;
        for (int row = 0; row < 3; row++) begin
            w[(row*3+0)*8 +: 8] = l;
            w[(row*3+1)*8 +: 8] = m;
            w[(row*3+2)*8 +: 8] = r;
        end
        return w;
    endfunction

    function automatic logic [71:0] centre(input logic [7:0] v);
        logic [71:0] w;
        w = '0;
        w[32 +: 8] = v;
        return w;
    endfunction

    task automatic write_coef(input logic [3:0] addr, input int val);
        coef_wr_en   = 1'b1;
        coef_wr_addr = addr;
        coef_wr_data = 8'(val);
        @(posedge clk); #1;
        coef_wr_en   = 1'b0;
    endtask

    task automatic load_coefs(input int c [9]);
        for (int i = 0; i < 9; i++) write_coef(4'(i), c[i]);
    endtask

    // Presents one window with out_ready=1 and returns the first result seen.
    task automatic run_one(input logic [71:0] w, output logic [7:0] d, output bit ok);
        out_ready = 1'b1;
        in_data   = w;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        ok = 1'b0;
        d  = '0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                d  = out_data;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== 8'd0) begin
            failures++; $display("FAIL reset_out_data: got %0d want 0", out_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_latency;
        cfg_shift = 4'd4;
        cfg_abs   = 1'b0;
        out_ready = 1'b1;
        in_data   = uni(8'd100);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL latency_early_%0d: out_valid got %b want 0", c, out_valid);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL latency_valid: out_valid got %b want 1", out_valid);
        end
        checks++;
        if (out_data !== 8'd100) begin
            failures++; $display("FAIL latency_data: got %0d want 100", out_data);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL latency_single: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_sobel;
        logic [7:0] d;
        bit ok;
        load_coefs(SOBEL_GX);

        cfg_shift = 4'd0; cfg_abs = 1'b0;
        run_one(cols(8'd0, 8'd77, 8'd255), d, ok);
        checks++;
        if (!ok || d !== 8'd255) begin
            failures++; $display("FAIL sobel_pos_sat: got %0d (valid %0d) want 255", d, ok);
        end

        cfg_abs = 1'b1;
        run_one(cols(8'd255, 8'd77, 8'd0), d, ok);
        checks++;
        if (!ok || d !== 8'd255) begin
            failures++; $display("FAIL sobel_neg_abs: got %0d (valid %0d) want 255", d, ok);
        end

        cfg_abs = 1'b0;
        run_one(cols(8'd255, 8'd77, 8'd0), d, ok);
        checks++;
        if (!ok || d !== 8'd0) begin
            failures++; $display("FAIL sobel_neg_clamp: got %0d (valid %0d) want 0", d, ok);
        end

        cfg_shift = 4'd2; cfg_abs = 1'b0;
        run_one(cols(8'd0, 8'd77, 8'd10), d, ok);
        checks++;
        if (!ok || d !== 8'd10) begin
            failures++; $display("FAIL sobel_pos_shift: got %0d (valid %0d) want 10", d, ok);
        end

        cfg_abs = 1'b1;
        run_one(cols(8'd13, 8'd0, 8'd0), d, ok);
        checks++;
        if (!ok || d !== 8'd13) begin
            failures++; $display("FAIL sobel_neg_abs_shift: got %0d (valid %0d) want 13", d, ok);
        end

        cfg_abs = 1'b0;
        load_coefs(GAUSS_COEF);
    endtask

    task automatic test_round;
        logic [7:0] d;
        bit ok;
        int exp_a, exp_b;
`ifdef CONV3X3_ROUND_EN
        exp_a = 2; exp_b = 3;
`else
        exp_a = 1; exp_b = 2;
`endif
        cfg_abs = 1'b0;
        cfg_shift = 4'd4;
        run_one(centre(8'd6), d, ok);
        checks++;
        if (!ok || d !== 8'(exp_a)) begin
            failures++; $display("FAIL round_24_sh4: got %0d (valid %0d) want %0d", d, ok, exp_a);
        end
        cfg_shift = 4'd3;
        run_one(centre(8'd5), d, ok);
        checks++;
        if (!ok || d !== 8'(exp_b)) begin
            failures++; $display("FAIL round_20_sh3: got %0d (valid %0d) want %0d", d, ok, exp_b);
        end
        cfg_shift = 4'd0;
        run_one(centre(8'd6), d, ok);
        checks++;
        if (!ok || d !== 8'd24) begin
            failures++; $display("FAIL round_sh0: got %0d (valid %0d) want 24", d, ok);
        end
    endtask

    task automatic test_extreme;
        logic [7:0] d;
        bit ok;
        int exp_e;
`ifdef CONV3X3_ROUND_EN
        exp_e = 9;
`else
        exp_e = 8;
`endif
        for (int i = 0; i < 9; i++) write_coef(4'(i), -128);
        cfg_shift = 4'd15; cfg_abs = 1'b1;
        run_one(uni(8'd255), d, ok);
        checks++;
        if (!ok || d !== 8'(exp_e)) begin
            failures++; $display("FAIL extreme_abs: got %0d (valid %0d) want %0d", d, ok, exp_e);
        end
        cfg_abs = 1'b0;
        run_one(uni(8'd255), d, ok);
        checks++;
        if (!ok || d !== 8'd0) begin
            failures++; $display("FAIL extreme_clamp: got %0d (valid %0d) want 0", d, ok);
        end
        load_coefs(GAUSS_COEF);
    endtask

    task automatic test_back_to_back;
        int sent, rcv;
        bit holding, saw_stall, accepted;
        logic [7:0] held;
        cfg_shift = 4'd4; cfg_abs = 1'b0;
        sent = 0; rcv = 0; holding = 1'b0; saw_stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < 60 && rcv < 10; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 8);
            in_valid  = (sent < 10);
            in_data   = uni(8'((sent + 1) * 25));
            #1;
            if (holding) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    failures++; $display("FAIL bp_hold_stable: got %0d valid %b want %0d valid 1", out_data, out_valid, held);
                end
            end
            if (out_valid === 1'b1 && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++; $display("FAIL bp_in_ready_stall: got %b want 0", in_ready);
                end
                saw_stall = 1'b1;
            end
            holding = (out_valid === 1'b1) && !out_ready;
            held    = out_data;
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (out_data !== 8'((rcv + 1) * 25)) begin
                    failures++; $display("FAIL bp_order_%0d: got %0d want %0d", rcv, out_data, (rcv + 1) * 25);
                end
                rcv++;
            end
            accepted = in_valid && (in_ready === 1'b1);
            @(posedge clk); #1;
            if (accepted) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rcv != 10 || sent != 10) begin
            failures++; $display("FAIL bp_count: got rcv=%0d sent=%0d want 10/10", rcv, sent);
        end
        checks++;
        if (!saw_stall) begin
            failures++; $display("FAIL bp_stall_seen: got 0 want 1");
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_no_dup: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_coef_midstream;
        int exp_v [7] = '{160, 176, 192, 104, 112, 120, 128};
        int rcv, first, last;
        cfg_shift = 4'd0; cfg_abs = 1'b0; out_ready = 1'b1;
        rcv = 0; first = 0; last = 0;
        for (int cyc = 0; cyc < 20 && rcv < 7; cyc++) begin
            in_valid     = (cyc < 7);
            in_data      = uni(8'(10 + cyc));
            coef_wr_en   = (cyc == 2) || (cyc == 4);
            coef_wr_addr = (cyc == 4) ? 4'd12 : 4'd4;
            coef_wr_data = (cyc == 4) ? 8'd0 : 8'hFC;
            #1;
            if (out_valid === 1'b1) begin
                checks++;
                if (out_data !== 8'(exp_v[rcv])) begin
                    failures++; $display("FAIL coef_mid_%0d: got %0d want %0d", rcv, out_data, exp_v[rcv]);
                end
                if (rcv == 0) first = cyc;
                last = cyc;
                rcv++;
            end
            @(posedge clk); #1;
        end
        coef_wr_en = 1'b0;
        in_valid   = 1'b0;
        checks++;
        if (rcv != 7 || last - first != 6) begin
            failures++; $display("FAIL coef_mid_throughput: got rcv=%0d span=%0d want 7/6", rcv, last - first);
        end
    endtask

    task automatic test_async_reset;
        logic [7:0] d;
        bit ok;
        int spurious;
        cfg_shift = 4'd0; cfg_abs = 1'b0; out_ready = 1'b1;
        in_data  = uni(8'd10);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL areset_pre_valid: got %b want 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'd0) begin
            failures++; $display("FAIL areset_immediate: valid %b data %0d want 0/0", out_valid, out_data);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        spurious = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++; $display("FAIL areset_no_emit: got %0d valid cycles want 0", spurious);
        end
        run_one(uni(8'd10), d, ok);
        checks++;
        if (!ok || d !== 8'd160) begin
            failures++; $display("FAIL areset_coef_default: got %0d (valid %0d) want 160", d, ok);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
        cfg_shift = '0; cfg_abs = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        test_reset;
        test_latency;
        test_sobel;
        test_round;
        test_extreme;
        test_back_to_back;
        test_coef_midstream;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
